// File: rtl/gshare_bht.sv
// Branch history table with 2^INDEX_W saturating counters, indexed by PC (bimodal)
// or PC XOR global history (gshare); the table is swept to CTR_INIT after every reset.
module gshare_bht #(
    parameter int INDEX_W  = 6,
    parameter int CTR_W    = 2,
    parameter int GHR_W    = 6,
    parameter int MODE     = 1,
    parameter int CTR_INIT = 0
) (
    input  logic               clk,
    input  logic               rst,
    input  logic [INDEX_W-1:0] if_pc,
    input  logic               if_branch,
    output logic               pred_taken,
    output logic [INDEX_W-1:0] pred_idx,
    output logic [GHR_W-1:0]   pred_ghr,
    input  logic               ex_valid,
    input  logic [INDEX_W-1:0] ex_idx,
    input  logic               ex_taken,
    input  logic               ex_mispredict,
    input  logic [GHR_W-1:0]   ex_ghr,
    output logic               init_busy
);

    localparam int DEPTH = 1 << INDEX_W;
    localparam logic [CTR_W-1:0] CTR_MAX = '1;

    typedef enum logic {S_INIT, S_RUN} state_e;

    state_e             state_q, state_d;
    logic [INDEX_W-1:0] ptr_q, ptr_d;
    logic [GHR_W-1:0]   ghr_q, ghr_d;
    logic [CTR_W-1:0]   ctr_q [DEPTH];
    logic [INDEX_W-1:0] rd_idx;
    logic [CTR_W-1:0]   upd_ctr, upd_next;
    logic               running;

    // Shift a new outcome into the LSB; for GHR_W == 1 this degenerates to a direct load.
    function automatic logic [GHR_W-1:0] shift_in(input logic [GHR_W-1:0] g, input logic b);
        return GHR_W'({g, b});
    endfunction

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= S_INIT;
            ptr_q   <= '0;
            ghr_q   <= '0;
        end else begin
            state_q <= state_d;
            ptr_q   <= ptr_d;
            ghr_q   <= ghr_d;
        end
    end

    // NOTE: every combinational output gets a default first so no path infers a latch.
    always_comb begin
        state_d   = state_q;
        ptr_d     = ptr_q;
        init_busy = 1'b0;
        case (state_q)
            S_INIT: begin
                init_busy = 1'b1;
                ptr_d     = ptr_q + 1'b1;
                if (&ptr_q) state_d = S_RUN;
            end
            S_RUN:   ;
            default: state_d = S_INIT;
        endcase
    end

    assign running = (state_q == S_RUN);

    assign rd_idx     = (MODE == 0) ? if_pc : (if_pc ^ INDEX_W'(ghr_q));
    assign pred_idx   = rd_idx;
    assign pred_ghr   = ghr_q;
    assign pred_taken = running & ctr_q[rd_idx][CTR_W-1];

    // Repair from a resolved mispredict outranks the speculative fetch shift.
    always_comb begin
        ghr_d = ghr_q;
        if (running) begin
            if (ex_valid && ex_mispredict) ghr_d = shift_in(ex_ghr, ex_taken);
            else if (if_branch)            ghr_d = shift_in(ghr_q, pred_taken);
        end
    end

    assign upd_ctr = ctr_q[ex_idx];

    always_comb begin
        upd_next = upd_ctr;
        if (ex_taken) begin
            if (upd_ctr != CTR_MAX) upd_next = upd_ctr + 1'b1;
        end else begin
            if (upd_ctr != '0) upd_next = upd_ctr - 1'b1;
        end
    end

    // NOTE: the counter array has no reset; the init sweep establishes its contents,
    // and writes land on the edge so a same-cycle read sees the old value.
    always_ff @(posedge clk) begin
        if (!rst) begin
            if (state_q == S_INIT)  ctr_q[ptr_q]  <= CTR_W'(CTR_INIT);
            else if (ex_valid)      ctr_q[ex_idx] <= upd_next;
        end
    end

endmodule

// File: tb/tb_gshare_bht.sv
// Directed bench for gshare_bht: one bimodal and one gshare instance, scoreboard queue
// filled by the stimulus and drained by a negedge monitor.
module tb_gshare_bht;

    logic       clk = 1'b0;
    logic       rst;
    logic [5:0] if_pc, ex_idx, ex_ghr;
    logic       ex_taken, ex_mispredict;

    logic       if_branch_b, ex_valid_b, pred_taken_b, init_busy_b;
    logic [5:0] pred_idx_b, pred_ghr_b;
    logic       if_branch_g, ex_valid_g, pred_taken_g, init_busy_g;
    logic [5:0] pred_idx_g, pred_ghr_g;

    always #5 clk = ~clk;

    gshare_bht #(.MODE(0)) dut_b (
        .clk(clk), .rst(rst), .if_pc(if_pc), .if_branch(if_branch_b),
        .pred_taken(pred_taken_b), .pred_idx(pred_idx_b), .pred_ghr(pred_ghr_b),
        .ex_valid(ex_valid_b), .ex_idx(ex_idx), .ex_taken(ex_taken),
        .ex_mispredict(ex_mispredict), .ex_ghr(ex_ghr), .init_busy(init_busy_b)
    );

    gshare_bht #(.MODE(1)) dut_g (
        .clk(clk), .rst(rst), .if_pc(if_pc), .if_branch(if_branch_g),
        .pred_taken(pred_taken_g), .pred_idx(pred_idx_g), .pred_ghr(pred_ghr_g),
        .ex_valid(ex_valid_g), .ex_idx(ex_idx), .ex_taken(ex_taken),
        .ex_mispredict(ex_mispredict), .ex_ghr(ex_ghr), .init_busy(init_busy_g)
    );

    typedef enum {S_PT_B, S_PI_B, S_PG_B, S_BUSY_B, S_PT_G, S_PI_G, S_PG_G, S_BUSY_G, S_BUSYLEN} sel_e;
    typedef struct {
        string name;
        sel_e  sel;
        int    exp;
    } item_t;

    item_t sb_q[$];
    int    n_cmp = 0;
    int    n_bad = 0;
    int    busy_len = 0;

    function automatic int actual(sel_e s);
        case (s)
            S_PT_B:   return int'(pred_taken_b);
            S_PI_B:   return int'(pred_idx_b);
            S_PG_B:   return int'(pred_ghr_b);
            S_BUSY_B: return int'(init_busy_b);
            S_PT_G:   return int'(pred_taken_g);
            S_PI_G:   return int'(pred_idx_g);
            S_PG_G:   return int'(pred_ghr_g);
            S_BUSY_G: return int'(init_busy_g);
            default:  return busy_len;
        endcase
    endfunction

    task automatic expect_val(input string name, input sel_e sel, input int exp);
        item_t it;
        it.name = name;
        it.sel  = sel;
        it.exp  = exp;
        sb_q.push_back(it);
    endtask

    // Monitor: outputs are stable at the falling edge, compare everything queued so far.
    initial begin : monitor
        item_t it;
        int    a;
        forever begin
            @(negedge clk);
            while (sb_q.size() > 0) begin
                it = sb_q.pop_front();
                a  = actual(it.sel);
                n_cmp++;
                if (a !== it.exp) begin
                    n_bad++;
                    $display("FAIL %s: got %0d, expected %0d", it.name, a, it.exp);
                end
            end
        end
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic train(input bit g, input logic [5:0] idx, input bit tk, input int n);
        ex_idx        = idx;
        ex_taken      = tk;
        ex_mispredict = 1'b0;
        if (g) ex_valid_g = 1'b1;
        else   ex_valid_b = 1'b1;
        repeat (n) step();
        ex_valid_b = 1'b0;
        ex_valid_g = 1'b0;
    endtask

    task automatic count_busy();
        busy_len = 0;
        for (int i = 0; i < 200; i++) begin
            @(negedge clk);
            if (!init_busy_b) break;
            busy_len++;
        end
    endtask

    initial begin : stim
        rst = 1'b1;
        if_pc = '0; ex_idx = '0; ex_ghr = '0; ex_taken = 1'b0; ex_mispredict = 1'b0;
        if_branch_b = 1'b0; ex_valid_b = 1'b0; if_branch_g = 1'b0; ex_valid_g = 1'b0;

        step();
        rst = 1'b0;
        expect_val("rst_busy_b", S_BUSY_B, 1);
        expect_val("rst_busy_g", S_BUSY_G, 1);
        expect_val("rst_ghr_b", S_PG_B, 0);
        expect_val("rst_ghr_g", S_PG_G, 0);
        expect_val("init_pred_b", S_PT_B, 0);
        count_busy();
        expect_val("init_len", S_BUSYLEN, 64);
        expect_val("run_busy_b", S_BUSY_B, 0);
        expect_val("run_busy_g", S_BUSY_G, 0);

        for (int pc = 0; pc < 64; pc++) begin
            step();
            if_pc = 6'(pc);
            expect_val($sformatf("swept_b_%0d", pc), S_PT_B, 0);
            expect_val($sformatf("swept_g_%0d", pc), S_PT_G, 0);
        end
        expect_val("run_ghr_b", S_PG_B, 0);
        expect_val("run_ghr_g", S_PG_G, 0);

        // Bimodal saturation at index 5
        step();
        train(1'b0, 6'd5, 1'b1, 4); if_pc = 6'd5; expect_val("sat_up4", S_PT_B, 1);
        train(1'b0, 6'd5, 1'b1, 1); expect_val("sat_hi_nowrap", S_PT_B, 1);
        train(1'b0, 6'd5, 1'b0, 5); expect_val("sat_lo", S_PT_B, 0);
        train(1'b0, 6'd5, 1'b1, 1); expect_val("sat_lo_nowrap1", S_PT_B, 0);
        train(1'b0, 6'd5, 1'b1, 1); expect_val("sat_lo_nowrap2", S_PT_B, 1);

        // Hysteresis at index 9
        train(1'b0, 6'd9, 1'b1, 3); if_pc = 6'd9; expect_val("hyst_at3", S_PT_B, 1);
        train(1'b0, 6'd9, 1'b0, 1); expect_val("hyst_1nt", S_PT_B, 1);
        train(1'b0, 6'd9, 1'b0, 1); expect_val("hyst_2nt", S_PT_B, 0);

        // Same-cycle read and update of index 9 (counter 1 -> 2)
        ex_valid_b = 1'b1; ex_idx = 6'd9; ex_taken = 1'b1;
        expect_val("bypass_old", S_PT_B, 0);
        step();
        ex_valid_b = 1'b0;
        expect_val("bypass_new", S_PT_B, 1);

        // Bimodal still keeps a GHR but indexes by PC alone
        ex_valid_b = 1'b1; ex_mispredict = 1'b1; ex_ghr = 6'b000001; ex_taken = 1'b1; ex_idx = 6'd63;
        step();
        ex_valid_b = 1'b0; ex_mispredict = 1'b0; if_pc = 6'd12;
        expect_val("bimodal_ghr", S_PG_B, 3);
        expect_val("bimodal_idx", S_PI_B, 12);

        // Gshare: load GHR = 000101 by repair, then check the XOR index
        ex_valid_g = 1'b1; ex_mispredict = 1'b1; ex_ghr = 6'b000010; ex_taken = 1'b1; ex_idx = 6'd63;
        step();
        ex_valid_g = 1'b0; ex_mispredict = 1'b0; if_pc = 6'b001100;
        expect_val("gshare_ghr", S_PG_G, 5);
        expect_val("gshare_idx", S_PI_G, 9);
        train(1'b1, 6'd9, 1'b1, 2);
        expect_val("gshare_pred", S_PT_G, 1);

        if_branch_g = 1'b1;
        step();
        if_branch_g = 1'b0;
        expect_val("spec_shift_t", S_PG_G, 11);

        if_pc = 6'd2;
        expect_val("prio_idx", S_PI_G, 9);
        expect_val("prio_pred", S_PT_G, 1);
        if_branch_g = 1'b1; ex_valid_g = 1'b1; ex_mispredict = 1'b1;
        ex_ghr = 6'b110000; ex_taken = 1'b0; ex_idx = 6'd63;
        step();
        if_branch_g = 1'b0; ex_valid_g = 1'b0; ex_mispredict = 1'b0;
        expect_val("repair_prio", S_PG_G, 32);

        ex_mispredict = 1'b1; ex_ghr = 6'b111111; ex_taken = 1'b1;
        step();
        ex_mispredict = 1'b0;
        expect_val("mispredict_unqualified", S_PG_G, 32);

        if_pc = 6'd0;
        expect_val("nt_pred", S_PT_G, 0);
        if_branch_g = 1'b1;
        step();
        if_branch_g = 1'b0;
        expect_val("spec_shift_nt", S_PG_G, 0);

        ex_valid_g = 1'b1; ex_mispredict = 1'b1; ex_ghr = 6'b000111; ex_taken = 1'b1; ex_idx = 6'd63;
        step();
        ex_valid_g = 1'b0; ex_mispredict = 1'b0; if_pc = 6'd9;
        expect_val("pre_rst_ghr", S_PG_G, 15);
        expect_val("pre_rst_pred", S_PT_B, 1);

        // Reset from RUN: GHR clears, predictions gated, history frozen during the sweep
        rst = 1'b1;
        step();
        rst = 1'b0;
        expect_val("rerst_busy", S_BUSY_B, 1);
        expect_val("rerst_ghr", S_PG_G, 0);
        expect_val("init_gate", S_PT_B, 0);
        ex_valid_g = 1'b1; ex_mispredict = 1'b1; ex_ghr = 6'b111111; ex_taken = 1'b1; if_branch_g = 1'b1;
        step();
        ex_valid_g = 1'b0; ex_mispredict = 1'b0; if_branch_g = 1'b0;
        expect_val("init_no_ghr", S_PG_G, 0);
        repeat (18) step();
        expect_val("mid_init_busy", S_BUSY_B, 1);

        // Reset mid-sweep restarts a full sweep
        rst = 1'b1;
        step();
        rst = 1'b0;
        count_busy();
        expect_val("restart_len", S_BUSYLEN, 64);
        step();
        if_pc = 6'd9;
        expect_val("resweep_clear", S_PT_B, 0);

        repeat (3) @(negedge clk);
        if (sb_q.size() != 0) begin
            n_cmp++;
            n_bad++;
            $display("FAIL drain: got %0d pending, expected 0", sb_q.size());
        end
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
